// File: rtl/fetch_queue.sv
// Sequential instruction fetch with a PC-tagged in-order prefetch FIFO; redirect flushes and drops in-flight words.
// Grant in t -> word on instr in t+2; issue stalls at FIFO entries + outstanding == DEPTH, responses never stall.
module fetch_queue_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CW-1:0]    count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_vld_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)      rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_vld_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_vld_i && !clr_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] target_pc;
  logic [FW-1:0]         head;
  logic                  issue, rsp_live, push, pop;

  assign target_pc = redirect_pc & ~DATA_WIDTH'(3);

  // Budget uses registered occupancy only, so a pop frees a slot one cycle later.
  assign imem_req    = !RST && !redirect &&
                       (({1'b0, count} + {1'b0, outstanding_q}) < (CW + 1)'(DEPTH));
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = !RST && !redirect && (count != '0);
  assign instr       = head[FW-1:DATA_WIDTH];
  assign instr_pc    = head[DATA_WIDTH-1:0];

  assign issue    = imem_req && imem_gnt;
  assign rsp_live = imem_rvalid && (outstanding_q != '0);
  assign pop      = instr_valid && instr_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q - CW'(rsp_live);
    drop_d        = drop_q;
    push          = 1'b0;
    if (redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_d     = outstanding_d;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + DATA_WIDTH'(4);
        outstanding_d = outstanding_d + CW'(1);
      end
      if (rsp_live) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + DATA_WIDTH'(4);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_queue_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .clr_i      (RST || redirect),
    .push_vld_i (push),
    .push_dat_i ({imem_rdata, resp_pc_q}),
    .pop_i      (pop),
    .head_dat_o (head),
    .count_o    (count)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, corner sequences, then random traffic against a queue-based model.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A5_0000;

  logic        CLK, RST, imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

  fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
  typedef struct {
    logic rst, gnt, rsp, rdy, redir; logic [31:0] rpc;
    logic e_req; logic [31:0] e_addr; logic e_vld; logic [31:0] e_pc;
  } vec_t;

  // Reference state: delivered words, in-flight requests (1 = live, 0 = to be discarded), PCs.
  ent_t        fq[$];
  bit          oq[$];
  logic [31:0] memq[$];
  logic [31:0] m_fpc = 32'h0, m_rpc = 32'h0;
  logic        m_req, m_vld;
  logic        rst_k, gnt_k, rsp_k, rdy_k, redir_k;
  logic [31:0] rpc_k;
  int          n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic begin_cycle();
    imem_rvalid = !rst_k && rsp_k && (memq.size() > 0);
    imem_rdata  = imem_rvalid ? (memq[0] ^ K) : 32'hDEAD_BEEF;
    RST = rst_k; imem_gnt = gnt_k; instr_ready = rdy_k; redirect = redir_k; redirect_pc = rpc_k;
    #2;
    m_req = !rst_k && !redir_k && ((fq.size() + oq.size()) < DEPTH);
    m_vld = !rst_k && !redir_k && (fq.size() != 0);
    chk("imem_req", imem_req, m_req);
    if (m_req) chk("imem_addr", imem_addr, m_fpc);
    chk("instr_valid", instr_valid, m_vld);
    if (m_vld) begin
      chk("instr_pc", instr_pc, fq[0].pc);
      chk("instr", instr, fq[0].ins);
    end
  endtask

  task automatic end_cycle();
    bit   live;
    ent_t e;
    if (rst_k) begin
      fq.delete(); oq.delete(); m_fpc = 32'h0; m_rpc = 32'h0;
    end else begin
      if (imem_rvalid) chk("rvalid_has_outstanding", 32'(oq.size() != 0), 32'd1);
      if (redir_k) begin
        fq.delete();
        if (imem_rvalid && oq.size() != 0) void'(oq.pop_front());
        foreach (oq[i]) oq[i] = 1'b0;
        m_fpc = rpc_k & ~32'd3;
        m_rpc = rpc_k & ~32'd3;
      end else begin
        if (m_vld && rdy_k) void'(fq.pop_front());
        if (imem_rvalid && oq.size() != 0) begin
          live = oq.pop_front();
          if (live) begin
            e.ins = imem_rdata; e.pc = m_rpc;
            fq.push_back(e);
            m_rpc = m_rpc + 32'd4;
          end
        end
        if (m_req && gnt_k) begin
          oq.push_back(1'b1);
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
    // Memory environment reacts to what the DUT actually issued.
    if (rst_k) memq.delete();
    else begin
      if (imem_rvalid) void'(memq.pop_front());
      if (imem_req && imem_gnt) memq.push_back(imem_addr);
    end
    @(posedge CLK); #1;
  endtask

  task automatic cyc();
    begin_cycle();
    end_cycle();
  endtask

  task automatic set_k(input logic r, input logic g, input logic s, input logic d, input logic x,
                       input logic [31:0] p);
    rst_k = r; gnt_k = g; rsp_k = s; rdy_k = d; redir_k = x; rpc_k = p;
  endtask

  function automatic vec_t mk(input logic r, g, s, d, x, input logic [31:0] p,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.gnt = g; v.rsp = s; v.rdy = d; v.redir = x; v.rpc = p;
    v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_pc = ep;
    return v;
  endfunction

  vec_t        tbl [18];
  logic [31:0] wrap_exp [3];
  int          k, grants;
  logic [31:0] hold;

  initial begin
    tbl[0]  = mk(1, 1, 1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    tbl[1]  = mk(1, 1, 1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    tbl[2]  = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0);
    tbl[3]  = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0);
    tbl[4]  = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'h8,   1, 32'h0);
    tbl[5]  = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'hC,   1, 32'h4);
    tbl[6]  = mk(0, 1, 1, 1, 1, 32'h40,  0, 32'h0,   0, 32'h0);
    tbl[7]  = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'h40,  0, 32'h0);
    tbl[8]  = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'h44,  0, 32'h0);
    tbl[9]  = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'h48,  1, 32'h40);
    tbl[10] = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'h4C,  1, 32'h44);
    tbl[11] = mk(0, 1, 0, 1, 0, 32'h0,   1, 32'h50,  1, 32'h48);
    tbl[12] = mk(0, 1, 0, 1, 1, 32'h103, 0, 32'h0,   0, 32'h0);
    tbl[13] = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
    tbl[14] = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    tbl[15] = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'h108, 0, 32'h0);
    tbl[16] = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'h10C, 1, 32'h100);
    tbl[17] = mk(0, 1, 1, 1, 0, 32'h0,   1, 32'h110, 1, 32'h104);
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;

    set_k(1, 0, 0, 0, 0, 32'h0);
    RST = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 18; i++) begin
      set_k(tbl[i].rst, tbl[i].gnt, tbl[i].rsp, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
      begin_cycle();
      chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_vld", i), instr_valid, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_pc ^ K);
      end
      end_cycle();
    end

    // Drain with grants withheld so the later sequences start empty.
    set_k(0, 0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 40 && (fq.size() + oq.size()) != 0; i++) cyc();
    chk("drain_done", 32'(fq.size() + oq.size()), 32'd0);

    // Stalled grant: request and address must hold.
    hold = m_fpc;
    for (int i = 0; i < 5; i++) begin
      begin_cycle();
      chk("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, hold);
      end_cycle();
    end

    // Backpressure: exactly DEPTH grants, then request drops.
    set_k(0, 1, 1, 0, 0, 32'h0);
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      begin_cycle();
      if (imem_req && imem_gnt) grants++;
      if (i == 9) chk("bp_req_off", imem_req, 1'b0);
      end_cycle();
    end
    chk("bp_grants", grants, DEPTH);
    chk("bp_buffered", 32'(fq.size()), DEPTH);
    set_k(0, 1, 1, 1, 0, 32'h0);
    for (int i = 0; i < 15; i++) cyc();

    // Address wrap.
    set_k(0, 1, 1, 1, 1, 32'hFFFF_FFF8);
    cyc();
    set_k(0, 1, 1, 1, 0, 32'h0);
    k = 0;
    for (int i = 0; i < 30; i++) begin
      begin_cycle();
      if (k < 3 && m_vld) begin
        chk($sformatf("wrap_pc%0d", k), instr_pc, wrap_exp[k]);
        k++;
      end
      end_cycle();
    end
    chk("wrap_seen", k, 3);

    // Mid-stream reset.
    set_k(1, 1, 1, 1, 0, 32'h0);
    begin_cycle();
    chk("midrst_vld", instr_valid, 1'b0);
    chk("midrst_req", imem_req, 1'b0);
    end_cycle();
    set_k(0, 1, 1, 1, 0, 32'h0);
    begin_cycle();
    chk("postrst_req", imem_req, 1'b1);
    chk("postrst_addr", imem_addr, 32'h0);
    chk("postrst_vld", instr_valid, 1'b0);
    end_cycle();

    for (int i = 0; i < 600; i++) begin
      set_k(($urandom % 150) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
            ($urandom % 3) != 0, ($urandom % 25) == 0, $urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
